seletor_mapa_param: RTL

SELETOR_MAPA_PARAM -- requirements
Module: seletor_mapa_param

---
 rtl/seletor_mapa_param.sv | 116 +++++++++++
 1 files changed

// File: rtl/seletor_mapa_param.sv
// seletor_mapa_param: map selector with preview, commit and lock.
// Buttons are rising-edge detected. In SELECT the operator browses the preset
// maps and commits one. In LOCKED the selection is frozen until an unlock edge.
module seletor_mapa_param #(
  parameter int ROWS     = 5,
  parameter int COLS     = 7,
  parameter int NUM_MAPS = 4,
  // Flat preset table: map k at [k*MW +: MW], row r at [r*COLS +: COLS], row 0 at the LSB
  parameter logic [NUM_MAPS*ROWS*COLS-1:0] MAP_ROM = {
    // map3 (row4 .. row0)
    7'b0000111, 7'b0100010, 7'b0111000, 7'b0100001, 7'b0000111,
    // map2
    7'b1110000, 7'b0100000, 7'b0100000, 7'b1000010, 7'b1110111,
    // map1
    7'b1110111, 7'b1000010, 7'b0100000, 7'b0100000, 7'b1110000,
    // map0
    7'b1000011, 7'b1110001, 7'b1000101, 7'b0001100, 7'b0000100
  },
  localparam int SW = (NUM_MAPS > 2) ? $clog2(NUM_MAPS) : 1,
  localparam int MW = ROWS * COLS,
  localparam int CW = $clog2(MW + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          btn_next,
  input  logic          btn_prev,
  input  logic          confirmar,
  input  logic          enable,
  input  logic          unlock,
  output logic [SW-1:0] sel_idx,
  output logic [MW-1:0] mapa_temp,
  output logic [MW-1:0] mapa,
  output logic [CW-1:0] cells_temp,
  output logic          locked,
  output logic          done
);

  typedef enum logic {S_SELECT = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_q, btn_d;      // {unlock, confirmar, prev, next} from last cycle
  logic [3:0]    btn_now, btn_edge;
  logic [SW-1:0] sel_idx_q, sel_idx_d;
  logic [MW-1:0] mapa_q, mapa_d;
  logic          done_q, done_d;
  logic          commit;

  function automatic logic [CW-1:0] popcount(input logic [MW-1:0] m);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MW; i++) cnt = cnt + CW'(m[i]);
    return cnt;
  endfunction

  assign btn_now  = {unlock, confirmar, btn_prev, btn_next};
  assign btn_edge = btn_now & ~btn_q;

  assign mapa_temp  = MAP_ROM[int'(sel_idx_q) * MW +: MW];
  assign cells_temp = popcount(mapa_temp);

  // Confirm takes priority over navigation in the same cycle
  assign commit = (state_q == S_SELECT) && btn_edge[2] && enable;

  // State and datapath registers, all cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_SELECT;
      btn_q     <= '0;
      sel_idx_q <= '0;
      mapa_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      sel_idx_q <= sel_idx_d;
      mapa_q    <= mapa_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: commit locks, unlock edge releases
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SELECT: if (commit) state_d = S_LOCKED;
      S_LOCKED: if (btn_edge[3]) state_d = S_SELECT;
      default:  state_d = S_SELECT;
    endcase
  end

  // Selection index, committed map, done pulse and edge history
  always_comb begin
    btn_d     = btn_now;
    sel_idx_d = sel_idx_q;
    mapa_d    = mapa_q;
    done_d    = 1'b0;
    if (commit) begin
      mapa_d = mapa_temp;
      done_d = 1'b1;
    end else if (state_q == S_SELECT) begin
      if (btn_edge[0] && !btn_edge[1])
        sel_idx_d = (sel_idx_q == SW'(NUM_MAPS - 1)) ? '0 : sel_idx_q + SW'(1);
      else if (btn_edge[1] && !btn_edge[0])
        sel_idx_d = (sel_idx_q == '0) ? SW'(NUM_MAPS - 1) : sel_idx_q - SW'(1);
    end
  end

  // Outputs derived from registered state
  always_comb begin
    locked  = (state_q == S_LOCKED);
    sel_idx = sel_idx_q;
    mapa    = mapa_q;
    done    = done_q;
  end

endmodule
